alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single RV32 ALU instance between NUM_REQ requesters, e.g. the execute stage and the branch/address-generation path.
- Uses a round-robin grant, latches the winner's operands and control, and drives the ALU ports from those registers.
- Registers the ALU result and returns it to the winner over a valid/ready response channel tagged with the requester id.
- Sits between the requesting pipeline units and the combinational ALU.

Parameters:
- NUM_REQ, default 2: number of requesters, 2 to 8.
- ID_W, default 1: width of requester id; must be at least clog2(NUM_REQ).

Ports:
- clk_w_i  in  1  clock
- rst_n_w_i  in  1  reset; one clock, asynchronous active-low reset
- req_valid_w_i  in  NUM_REQ  per-requester request valid
- req_ready_w_o  out  NUM_REQ  per-requester accept; at most one bit high
- req_a_data_w_i  in  32*NUM_REQ  operand A; slice i belongs to requester i
- req_b_data_w_i  in  32*NUM_REQ  operand B
- req_alu_control_w_i  in  4*NUM_REQ  ALU op code
- req_sub_flag_w_i  in  NUM_REQ  SUB vs ADDI select for op 4'b1000
- req_force_add_w_i  in  NUM_REQ  force-add for store address generation
- alu_a_data_w_o  out  32  to ALU operand A
- alu_b_data_w_o  out  32  to ALU operand B
- alu_control_w_o  out  4  to ALU control
- alu_addi_sub_flag_w_o  out  1  to ALU SUB/ADDI select
- alu_store_force_add_flag_w_o  out  1  to ALU force-add
- alu_res_w_i  in  32  ALU result
- rsp_valid_w_o  out  1  response valid
- rsp_ready_w_i  in  1  response accept
- rsp_data_w_o  out  32  registered ALU result
- rsp_id_w_o  out  ID_W  index of the requester that owns the response

Behaviour:
- FSM states: IDLE, EXEC, RESP. Encoding 2'b00, 2'b01, 2'b10.
- Reset (async, rst_n_w_i=0):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - All operand, control and flag registers = 0.
  - rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0.
- IDLE:
  - Combinational round-robin search starts at rr_ptr+1, modulo NUM_REQ.
  - The first requester with valid=1 gets req_ready=1 in the same cycle; that cycle is the handshake.
  - On the handshake: latch a, b, control, sub_flag, force_add and id; set rr_ptr=winner; go to EXEC.
  - No valid requests: stay in IDLE, all ready bits 0.
- EXEC:
  - ALU ports are driven from the latched registers.
  - At the clock edge: rsp_data<=alu_res_w_i, rsp_id<=latched id; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable.
  - rsp_ready_w_i=1 completes the transfer; go to IDLE.
  - rsp_ready_w_i=0 stalls indefinitely; no new request is accepted.
- ALU output ports hold the last latched values in every state, so they never toggle outside a grant.
- Timing:
  - Handshake at cycle T gives rsp_valid at T+2.
  - With rsp_ready tied high, throughput is one operation per 3 cycles.
- A requester may drop valid before it is granted; nothing is committed until req_ready is seen. After the handshake, requester inputs are don't-care.
- Simultaneous valids: only the round-robin winner is accepted; the others wait. A lone requester holding valid is re-granted every 3 cycles.
- Op codes and flags pass through unchanged; the ALU owns their semantics.
- Reset asserted mid-operation aborts immediately: the in-flight response is discarded and rsp_valid drops asynchronously.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_OP_CHK_EN.
- Defined:
  - Adds output rsp_err_w_o (1 bit, reset 0), registered in EXEC alongside rsp_data.
  - rsp_err_w_o=1 when the latched control is 4'b1100 or 4'b1110 and force_add=0.
  - When rsp_err_w_o=1, rsp_data is forced to 32'h0 instead of the ALU's X result.
- Undefined: no rsp_err_w_o port; the ALU result is passed through unconditionally.

Decomposition:
- Shared alu_pkg/header holds:
  - 4-bit ALU op code constants: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB/ADDI 1000, SRA 1101.
  - FSM state encodings.
  - Illegal op code list.
- One sub-module, rr_arbiter: combinational. Inputs are req vector and ptr; outputs are one-hot grant and grant index.

Test Plan:
- Single add: req0 a=5, b=7, ctrl=0000, rsp_ready=1. Response: ready0 at T, rsp_valid at T+2, data=12, id=0.
- Contention: req0 and req1 held valid continuously. Grants alternate 0,1,0,1 at T, T+3, T+6, T+9; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles in RESP. rsp_valid stays high, data/id stable, ready bits stay 0; the transfer completes in the cycle rsp_ready rises.
- SUB vs ADDI: ctrl=1000, a=10, b=3, sub=1 gives 7; sub=0 gives 13. force_add=1 with ctrl=0100 gives 13.
- Reset mid-operation: assert rst_n_w_i low in EXEC. rsp_valid=0, state IDLE, outputs 0; the next request goes to req0 first.
- ALU_ARB_ILLEGAL_OP_CHK_EN: ctrl=1100 gives rsp_err=1, data=0; ctrl=1101 with a=32'h80000000, b=4 gives rsp_err=0, data=32'hF8000000.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, FSM state
// encodings and the illegal op code list (used when ALU_ARB_ILLEGAL_OP_CHK_EN
// is defined).
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Op codes the ALU leaves undefined unless force-add overrides them
  localparam logic [3:0] ALU_ILLEGAL_OP0 = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL_OP1 = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == ALU_ILLEGAL_OP0) || (op == ALU_ILLEGAL_OP1);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (mod NUM_REQ)
// and returns the first active request as a one-hot grant plus its index.
module rr_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  // Two ordered passes: indices above ptr first, then wrap around from 0
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req[i] && (i > int'(ptr))) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req[i]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one RV32 ALU between NUM_REQ requesters with round-robin grant,
// latched operands and a registered, id-tagged valid/ready response.
// Optional macro ALU_ARB_ILLEGAL_OP_CHK_EN adds rsp_err_w_o and zeroes the
// result of illegal op codes.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk_w_i,
  input  logic                  rst_n_w_i,
  input  logic [NUM_REQ-1:0]    req_valid_w_i,
  output logic [NUM_REQ-1:0]    req_ready_w_o,
  input  logic [32*NUM_REQ-1:0] req_a_data_w_i,
  input  logic [32*NUM_REQ-1:0] req_b_data_w_i,
  input  logic [4*NUM_REQ-1:0]  req_alu_control_w_i,
  input  logic [NUM_REQ-1:0]    req_sub_flag_w_i,
  input  logic [NUM_REQ-1:0]    req_force_add_w_i,
  output logic [31:0]           alu_a_data_w_o,
  output logic [31:0]           alu_b_data_w_o,
  output logic [3:0]            alu_control_w_o,
  output logic                  alu_addi_sub_flag_w_o,
  output logic                  alu_store_force_add_flag_w_o,
  input  logic [31:0]           alu_res_w_i,
  output logic                  rsp_valid_w_o,
  input  logic                  rsp_ready_w_i,
  output logic [31:0]           rsp_data_w_o,
  output logic [ID_W-1:0]       rsp_id_w_o
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
  ,
  output logic                  rsp_err_w_o
`endif
);

  arb_state_e state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               handshake;

  logic [31:0] sel_a, sel_b;
  logic [3:0]  sel_ctrl;
  logic        sel_sub, sel_force;

  logic [31:0]     a_q, b_q;
  logic [3:0]      ctrl_q;
  logic            sub_q, force_q;
  logic [ID_W-1:0] id_q;

  logic [31:0]     rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [31:0]     rsp_result;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr_arbiter (
    .req      (req_valid_w_i),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  // State register; reset aborts any in-flight operation immediately
  always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
    if (!rst_n_w_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state and ready: only IDLE grants, and only to the round-robin winner
  always_comb begin
    state_d       = state_q;
    handshake     = 1'b0;
    req_ready_w_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any && rst_n_w_i) begin
          req_ready_w_o = grant;
          handshake     = 1'b1;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready_w_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pick the winner's operand slices
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_ctrl  = '0;
    sel_sub   = 1'b0;
    sel_force = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a     = req_a_data_w_i[i*32 +: 32];
        sel_b     = req_b_data_w_i[i*32 +: 32];
        sel_ctrl  = req_alu_control_w_i[i*4 +: 4];
        sel_sub   = req_sub_flag_w_i[i];
        sel_force = req_force_add_w_i[i];
      end
    end
  end

  // Latch operands and advance the round-robin pointer on the handshake only
  always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
    if (!rst_n_w_i) begin
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      sub_q    <= 1'b0;
      force_q  <= 1'b0;
      id_q     <= '0;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
    end else if (handshake) begin
      a_q      <= sel_a;
      b_q      <= sel_b;
      ctrl_q   <= sel_ctrl;
      sub_q    <= sel_sub;
      force_q  <= sel_force;
      id_q     <= grant_idx;
      rr_ptr_q <= grant_idx;
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
  logic op_illegal;
  logic rsp_err_q;
  assign op_illegal = is_illegal_op(ctrl_q) && !force_q;
  assign rsp_result = op_illegal ? 32'h0 : alu_res_w_i;

  // Error flag is captured together with the result in EXEC
  always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
    if (!rst_n_w_i)               rsp_err_q <= 1'b0;
    else if (state_q == ST_EXEC)  rsp_err_q <= op_illegal;
  end

  assign rsp_err_w_o = rsp_err_q;
`else
  assign rsp_result = alu_res_w_i;
`endif

  // Capture the ALU result and owner id at the end of EXEC
  always_ff @(posedge clk_w_i or negedge rst_n_w_i) begin
    if (!rst_n_w_i) begin
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else if (state_q == ST_EXEC) begin
      rsp_data_q <= rsp_result;
      rsp_id_q   <= id_q;
    end
  end

  assign alu_a_data_w_o               = a_q;
  assign alu_b_data_w_o               = b_q;
  assign alu_control_w_o              = ctrl_q;
  assign alu_addi_sub_flag_w_o        = sub_q;
  assign alu_store_force_add_flag_w_o = force_q;

  assign rsp_valid_w_o = (state_q == ST_RESP);
  assign rsp_data_w_o  = rsp_data_q;
  assign rsp_id_w_o    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (3 requesters): table-driven single
// operations, hand-written contention/backpressure/reset sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;

  logic                  clk_w_i = 1'b0;
  logic                  rst_n_w_i = 1'b0;
  logic [NUM_REQ-1:0]    req_valid_w_i;
  logic [NUM_REQ-1:0]    req_ready_w_o;
  logic [32*NUM_REQ-1:0] req_a_data_w_i;
  logic [32*NUM_REQ-1:0] req_b_data_w_i;
  logic [4*NUM_REQ-1:0]  req_alu_control_w_i;
  logic [NUM_REQ-1:0]    req_sub_flag_w_i;
  logic [NUM_REQ-1:0]    req_force_add_w_i;
  logic [31:0]           alu_a_data_w_o;
  logic [31:0]           alu_b_data_w_o;
  logic [3:0]            alu_control_w_o;
  logic                  alu_addi_sub_flag_w_o;
  logic                  alu_store_force_add_flag_w_o;
  logic [31:0]           alu_res_w_i;
  logic                  rsp_valid_w_o;
  logic                  rsp_ready_w_i;
  logic [31:0]           rsp_data_w_o;
  logic [ID_W-1:0]       rsp_id_w_o;
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
  logic                  rsp_err_w_o;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        sub;
    logic        fa;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  alu_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) dut (
    .clk_w_i                     (clk_w_i),
    .rst_n_w_i                   (rst_n_w_i),
    .req_valid_w_i               (req_valid_w_i),
    .req_ready_w_o               (req_ready_w_o),
    .req_a_data_w_i              (req_a_data_w_i),
    .req_b_data_w_i              (req_b_data_w_i),
    .req_alu_control_w_i         (req_alu_control_w_i),
    .req_sub_flag_w_i            (req_sub_flag_w_i),
    .req_force_add_w_i           (req_force_add_w_i),
    .alu_a_data_w_o              (alu_a_data_w_o),
    .alu_b_data_w_o              (alu_b_data_w_o),
    .alu_control_w_o             (alu_control_w_o),
    .alu_addi_sub_flag_w_o       (alu_addi_sub_flag_w_o),
    .alu_store_force_add_flag_w_o(alu_store_force_add_flag_w_o),
    .alu_res_w_i                 (alu_res_w_i),
    .rsp_valid_w_o               (rsp_valid_w_o),
    .rsp_ready_w_i               (rsp_ready_w_i),
    .rsp_data_w_o                (rsp_data_w_o),
    .rsp_id_w_o                  (rsp_id_w_o)
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
    ,
    .rsp_err_w_o                 (rsp_err_w_o)
`endif
  );

  always #5 clk_w_i = ~clk_w_i;

  // Behavioural RV32 ALU standing in for the real one; illegal ops give a marker value
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] ctrl, input logic sub,
                                            input logic fa);
    if (fa) return a + b;
    case (ctrl)
      4'b0000: return a + b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1000: return sub ? (a - b) : (a + b);
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic exp_err_of(input logic [3:0] ctrl, input logic fa);
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
    return ((ctrl == 4'b1100) || (ctrl == 4'b1110)) && !fa;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] ctrl, input logic sub,
                                          input logic fa);
    if (exp_err_of(ctrl, fa)) return 32'h0;
    return alu_model(a, b, ctrl, sub, fa);
  endfunction

  always_comb alu_res_w_i = alu_model(alu_a_data_w_o, alu_b_data_w_o, alu_control_w_o,
                                      alu_addi_sub_flag_w_o, alu_store_force_add_flag_w_o);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic check_err(input string name, input logic expected);
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
    checkOutput(name, 32'(rsp_err_w_o), 32'(expected));
`else
    checkOutput(name, 32'(expected), 32'(1'b0));
`endif
  endtask

  task automatic clear_inputs();
    req_valid_w_i       = '0;
    req_a_data_w_i      = '0;
    req_b_data_w_i      = '0;
    req_alu_control_w_i = '0;
    req_sub_flag_w_i    = '0;
    req_force_add_w_i   = '0;
    rsp_ready_w_i       = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl, input logic sub, input logic fa);
    req_a_data_w_i[r*32 +: 32]     = a;
    req_b_data_w_i[r*32 +: 32]     = b;
    req_alu_control_w_i[r*4 +: 4]  = ctrl;
    req_sub_flag_w_i[r]            = sub;
    req_force_add_w_i[r]           = fa;
  endtask

  task automatic do_reset();
    @(negedge clk_w_i);
    rst_n_w_i = 1'b0;
    clear_inputs();
    #1;
    checkOutput("reset rsp_valid", 32'(rsp_valid_w_o), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready_w_o), 32'd0);
    checkOutput("reset alu_a", alu_a_data_w_o, 32'd0);
    checkOutput("reset alu_b", alu_b_data_w_o, 32'd0);
    checkOutput("reset alu_ctrl", 32'(alu_control_w_o), 32'd0);
    checkOutput("reset alu_flags", {30'd0, alu_addi_sub_flag_w_o, alu_store_force_add_flag_w_o}, 32'd0);
    checkOutput("reset rsp_data", rsp_data_w_o, 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id_w_o), 32'd0);
    check_err("reset rsp_err", 1'b0);
    @(negedge clk_w_i);
    rst_n_w_i = 1'b1;
  endtask

  // One isolated transaction: handshake, EXEC port check, response check
  task automatic applyStimulus(input vec_t v);
    @(negedge clk_w_i);
    clear_inputs();
    set_req(v.req, v.a, v.b, v.ctrl, v.sub, v.fa);
    req_valid_w_i[v.req] = 1'b1;
    #1;
    checkOutput("vec handshake ready", 32'(req_ready_w_o), 32'd1 << v.req);
    checkOutput("vec handshake rsp_valid", 32'(rsp_valid_w_o), 32'd0);
    @(negedge clk_w_i);
    req_valid_w_i = '0;
    set_req(v.req, ~v.a, ~v.b, ~v.ctrl, ~v.sub, ~v.fa);
    #1;
    checkOutput("vec exec ready", 32'(req_ready_w_o), 32'd0);
    checkOutput("vec exec rsp_valid", 32'(rsp_valid_w_o), 32'd0);
    checkOutput("vec exec alu_a", alu_a_data_w_o, v.a);
    checkOutput("vec exec alu_b", alu_b_data_w_o, v.b);
    checkOutput("vec exec alu_ctrl", 32'(alu_control_w_o), 32'(v.ctrl));
    checkOutput("vec exec flags", {30'd0, alu_addi_sub_flag_w_o, alu_store_force_add_flag_w_o},
                {30'd0, v.sub, v.fa});
    @(negedge clk_w_i);
    #1;
    checkOutput("vec rsp_valid", 32'(rsp_valid_w_o), 32'd1);
    checkOutput("vec rsp_data", rsp_data_w_o, v.exp_data);
    checkOutput("vec rsp_id", 32'(rsp_id_w_o), 32'(v.req));
    check_err("vec rsp_err", v.exp_err);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] exp_ready;
    logic [3:0]  ops[12];
    logic [31:0] ra[NUM_REQ];
    logic [31:0] rb[NUM_REQ];
    logic [3:0]  rc[NUM_REQ];
    logic        rs[NUM_REQ];
    logic        rf[NUM_REQ];
    int          last_winner;
    int          winner;
    int          age;
    bit          outstanding;
    logic [31:0] m_data;
    logic [31:0] m_a;
    int          m_id;
    logic        m_err;

    vecs[0]  = '{0, 32'd5,          32'd7,          4'b0000, 1'b0, 1'b0, 32'd12,         1'b0};
    vecs[1]  = '{1, 32'd10,         32'd3,          4'b1000, 1'b1, 1'b0, 32'd7,          1'b0};
    vecs[2]  = '{2, 32'd10,         32'd3,          4'b1000, 1'b0, 1'b0, 32'd13,         1'b0};
    vecs[3]  = '{0, 32'd10,         32'd3,          4'b0100, 1'b0, 1'b1, 32'd13,         1'b0};
    vecs[4]  = '{1, 32'h80000000,   32'd4,          4'b1101, 1'b0, 1'b0, 32'hF8000000,   1'b0};
    vecs[5]  = '{2, 32'hFFFFFFFF,   32'd1,          4'b0010, 1'b0, 1'b0, 32'd1,          1'b0};
    vecs[6]  = '{0, 32'hFFFFFFFF,   32'd1,          4'b0011, 1'b0, 1'b0, 32'd0,          1'b0};
    vecs[7]  = '{1, 32'd1,          32'd31,         4'b0001, 1'b0, 1'b0, 32'h80000000,   1'b0};
    vecs[8]  = '{2, 32'hF0F0F0F0,   32'h0F0F0F0F,   4'b0111, 1'b0, 1'b0, 32'd0,          1'b0};
    vecs[9]  = '{0, 32'h12345678,   32'd4,          4'b0101, 1'b0, 1'b0, 32'h01234567,   1'b0};
`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
    vecs[10] = '{1, 32'd1,          32'd2,          4'b1100, 1'b0, 1'b0, 32'd0,          1'b1};
`else
    vecs[10] = '{1, 32'd1,          32'd2,          4'b1100, 1'b0, 1'b0, 32'hDEADBEEF,   1'b0};
`endif
    vecs[11] = '{2, 32'd1,          32'd2,          4'b1110, 1'b0, 1'b1, 32'd3,          1'b0};

    clear_inputs();
    do_reset();

    $display("[TB] table-driven single operations");
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    $display("[TB] contention between requester 0 and 1");
    do_reset();
    @(negedge clk_w_i);
    set_req(0, 32'd100, 32'd1, 4'b0000, 1'b0, 1'b0);
    set_req(1, 32'd200, 32'd2, 4'b1000, 1'b1, 1'b0);
    req_valid_w_i = 3'b011;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk_w_i);
      #1;
      exp_ready = (k % 3 == 0) ? NUM_REQ'(1 << ((k / 3) % 2)) : '0;
      checkOutput("contention ready", 32'(req_ready_w_o), 32'(exp_ready));
      checkOutput("contention rsp_valid", 32'(rsp_valid_w_o), (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) begin
        checkOutput("contention rsp_id", 32'(rsp_id_w_o), 32'((k / 3) % 2));
        checkOutput("contention rsp_data", rsp_data_w_o, ((k / 3) % 2 == 0) ? 32'd101 : 32'd198);
      end
    end

    $display("[TB] response backpressure");
    @(negedge clk_w_i);
    clear_inputs();
    set_req(2, 32'h1234, 32'h0F00, 4'b0110, 1'b0, 1'b0);
    set_req(0, 32'd1, 32'd1, 4'b0000, 1'b0, 1'b0);
    req_valid_w_i = 3'b100;
    rsp_ready_w_i = 1'b0;
    #1;
    checkOutput("bp handshake ready", 32'(req_ready_w_o), 32'b100);
    @(negedge clk_w_i);
    req_valid_w_i = 3'b001;
    #1;
    checkOutput("bp exec ready", 32'(req_ready_w_o), 32'd0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_w_i);
      #1;
      checkOutput("bp stall rsp_valid", 32'(rsp_valid_w_o), 32'd1);
      checkOutput("bp stall rsp_data", rsp_data_w_o, 32'h1F34);
      checkOutput("bp stall rsp_id", 32'(rsp_id_w_o), 32'd2);
      checkOutput("bp stall ready", 32'(req_ready_w_o), 32'd0);
    end
    @(negedge clk_w_i);
    rsp_ready_w_i = 1'b1;
    #1;
    checkOutput("bp release rsp_valid", 32'(rsp_valid_w_o), 32'd1);
    checkOutput("bp release ready", 32'(req_ready_w_o), 32'd0);
    @(negedge clk_w_i);
    #1;
    checkOutput("bp next grant ready", 32'(req_ready_w_o), 32'b001);
    checkOutput("bp next rsp_valid", 32'(rsp_valid_w_o), 32'd0);
    @(negedge clk_w_i);
    req_valid_w_i = '0;
    @(negedge clk_w_i);
    #1;
    checkOutput("bp next rsp_data", rsp_data_w_o, 32'd2);
    checkOutput("bp next rsp_id", 32'(rsp_id_w_o), 32'd0);

    $display("[TB] reset during EXEC");
    @(negedge clk_w_i);
    clear_inputs();
    set_req(1, 32'd9, 32'd9, 4'b0000, 1'b0, 1'b0);
    set_req(0, 32'd40, 32'd2, 4'b0000, 1'b0, 1'b0);
    req_valid_w_i = 3'b010;
    #1;
    checkOutput("rst handshake ready", 32'(req_ready_w_o), 32'b010);
    @(negedge clk_w_i);
    req_valid_w_i = '0;
    #1;
    checkOutput("rst exec alu_a", alu_a_data_w_o, 32'd9);
    rst_n_w_i = 1'b0;
    #1;
    checkOutput("rst mid rsp_valid", 32'(rsp_valid_w_o), 32'd0);
    checkOutput("rst mid alu_a", alu_a_data_w_o, 32'd0);
    checkOutput("rst mid rsp_data", rsp_data_w_o, 32'd0);
    @(negedge clk_w_i);
    #1;
    checkOutput("rst hold rsp_valid", 32'(rsp_valid_w_o), 32'd0);
    @(negedge clk_w_i);
    rst_n_w_i = 1'b1;
    req_valid_w_i = 3'b111;
    #1;
    checkOutput("rst first grant", 32'(req_ready_w_o), 32'b001);
    @(negedge clk_w_i);
    req_valid_w_i = '0;
    @(negedge clk_w_i);
    #1;
    checkOutput("rst first rsp_data", rsp_data_w_o, 32'd42);
    checkOutput("rst first rsp_id", 32'(rsp_id_w_o), 32'd0);

    $display("[TB] randomized run against reference model");
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1101, 4'b1100, 4'b1110};
    do_reset();
    last_winner = NUM_REQ - 1;
    outstanding = 1'b0;
    age = 0;
    m_data = '0;
    m_a = '0;
    m_id = 0;
    m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_w_i);
      for (int r = 0; r < NUM_REQ; r++) begin
        ra[r] = $urandom;
        rb[r] = $urandom;
        rc[r] = ops[$urandom_range(0, 11)];
        rs[r] = 1'($urandom_range(0, 1));
        rf[r] = ($urandom_range(0, 7) == 0);
        set_req(r, ra[r], rb[r], rc[r], rs[r], rf[r]);
        req_valid_w_i[r] = 1'($urandom_range(0, 1));
      end
      rsp_ready_w_i = ($urandom_range(0, 3) != 0);
      #1;
      if (!outstanding) begin
        winner = -1;
        for (int off = 1; off <= NUM_REQ; off++) begin
          if (winner < 0 && req_valid_w_i[(last_winner + off) % NUM_REQ])
            winner = (last_winner + off) % NUM_REQ;
        end
        exp_ready = (winner >= 0) ? NUM_REQ'(1 << winner) : '0;
        checkOutput("rand idle ready", 32'(req_ready_w_o), 32'(exp_ready));
        checkOutput("rand idle rsp_valid", 32'(rsp_valid_w_o), 32'd0);
        if (winner >= 0) begin
          outstanding = 1'b1;
          age = 0;
          last_winner = winner;
          m_id = winner;
          m_a = ra[winner];
          m_data = exp_rsp(ra[winner], rb[winner], rc[winner], rs[winner], rf[winner]);
          m_err = exp_err_of(rc[winner], rf[winner]);
        end
      end else begin
        age++;
        checkOutput("rand busy ready", 32'(req_ready_w_o), 32'd0);
        checkOutput("rand busy rsp_valid", 32'(rsp_valid_w_o), (age >= 2) ? 32'd1 : 32'd0);
        if (age == 1) checkOutput("rand exec alu_a", alu_a_data_w_o, m_a);
        if (age >= 2) begin
          checkOutput("rand rsp_data", rsp_data_w_o, m_data);
          checkOutput("rand rsp_id", 32'(rsp_id_w_o), 32'(m_id));
          check_err("rand rsp_err", m_err);
          if (rsp_ready_w_i) outstanding = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
